// File: rtl/uart_rx_stream_driver_if.sv
`timescale 1ns/1ps
// Receive-stream bundle: serial line and read request in; byte, strobe, fill level and error pulses out.
// master is the receiver side, slave is the consumer that feeds rxd and pulls bytes.
interface uart_rx_stream_driver_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic          rxd;
  logic          readclk;
  logic [7:0]    out;
  logic          outclk;
  logic [CW-1:0] count;
  logic          frame_err;
  logic          overflow;

  modport master (
    input  rxd, readclk,
    output out, outclk, count, frame_err, overflow
  );

  modport slave (
    output rxd, readclk,
    input  out, outclk, count, frame_err, overflow
  );
endinterface

// File: rtl/uart_rx_stream_driver.sv
`timescale 1ns/1ps
// 8N1 UART receiver with 3-sample majority vote feeding a byte FIFO drained one byte per readclk.
// Read latency 1 cycle; a full FIFO drops the new byte with an overflow pulse unless read in the push cycle.
module uart_rx_stream_driver #(
  parameter int CYCLES_PER_BIT = 10,
  parameter int FIFO_DEPTH     = 16
) (
  input logic                     clk,
  input logic                     rst,
  uart_rx_stream_driver_if.master bus
);
  localparam int H   = CYCLES_PER_BIT / 2;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CCW = $clog2(CYCLES_PER_BIT);
  localparam int SCW = $clog2(H);
  localparam logic [SCW-1:0] START_LAST = SCW'(H - 1);
  localparam logic [CCW-1:0] CYC_LAST   = CCW'(CYCLES_PER_BIT - 1);
  localparam logic [CW-1:0]  FULL_LVL   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, STOP, WAIT_IDLE} state_t;

  state_t         state_q, state_d;
  logic [1:0]     sync_q, hist_q;
  logic           rxd_s, maj;
  logic [SCW-1:0] start_cnt;
  logic [CCW-1:0] cyc_cnt;
  logic [3:0]     bit_cnt;
  logic [7:0]     shreg;
  logic           mid_bit, shift_en, push, pop, full, frame_err_d, overflow_d;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count_q;
  logic [7:0]     out_q;
  logic           outclk_q, frame_err_q, overflow_q;

  assign rxd_s   = sync_q[1];
  assign maj     = (rxd_s & hist_q[0]) | (rxd_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
  assign mid_bit = (cyc_cnt == CYC_LAST);
  assign full    = (count_q == FULL_LVL);
  assign pop     = bus.readclk && (count_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      hist_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], bus.rxd};
      hist_q <= {hist_q[0], rxd_s};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start_cnt == START_LAST) state_d = DATA;
      DATA:      if (mid_bit && bit_cnt == 4'd7) state_d = STOP;
      STOP:      if (mid_bit) state_d = maj ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rxd_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Stop-bit decision: good byte is pushed, or dropped when full and nobody is reading this cycle.
  always_comb begin
    shift_en    = 1'b0;
    push        = 1'b0;
    frame_err_d = 1'b0;
    overflow_d  = 1'b0;
    if (state_q == DATA && mid_bit) shift_en = 1'b1;
    if (state_q == STOP && mid_bit) begin
      if (!maj)              frame_err_d = 1'b1;
      else if (!full || pop) push        = 1'b1;
      else                   overflow_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_cnt <= '0;
      cyc_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
    end else begin
      if (state_q != IDLE || rxd_s)   start_cnt <= '0;
      else if (start_cnt != START_LAST) start_cnt <= start_cnt + SCW'(1);

      if (state_q == DATA || state_q == STOP) begin
        if (mid_bit) begin
          cyc_cnt <= '0;
          bit_cnt <= bit_cnt + 4'd1;
        end else begin
          cyc_cnt <= cyc_cnt + CCW'(1);
        end
      end else begin
        cyc_cnt <= '0;
        bit_cnt <= '0;
      end

      if (shift_en) shreg <= {maj, shreg[7:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  // When full, wr_ptr equals rd_ptr; the read below sees the old entry before this push lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      out_q       <= '0;
      outclk_q    <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        out_q  <= mem[rd_ptr];
      end
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
      outclk_q    <= pop;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.outclk    = outclk_q;
  assign bus.count     = count_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overflow  = overflow_q;
endmodule
